// File: rtl/bnn_threshold_packer_pkg.sv
// Shared types and constants for the BNN threshold/pack stage.
// Optional ones statistic is enabled in the top by BNN_PACK_STATS_EN.
package bnn_pkg;

  localparam int BNN_WORD_SIZE = 64;
  localparam int BNN_ACC_W     = 16;

  typedef struct packed {
    logic                 inv;
    logic [BNN_ACC_W-1:0] thr;
  } thr_entry_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FILL  = 1'b1
  } pack_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/bnn_threshold_packer_if.sv
// Bundles threshold-write, input stream, output stream and status signals.
// master drives stimulus / consumes words; slave is the packer itself.
interface bnn_threshold_packer_if #(
  parameter int WORD_SIZE   = 64,
  parameter int ACC_W       = 16,
  parameter int NUM_NEURONS = 256
);
  localparam int AW = $clog2(NUM_NEURONS);
  localparam int CW = $clog2(WORD_SIZE + 1);

  logic                 thr_wr_en;
  logic [AW-1:0]        thr_wr_addr;
  logic [ACC_W-1:0]     thr_wr_data;
  logic                 thr_wr_inv;

  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_W-1:0]     in_sum;
  logic                 in_last;

  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_word;
  logic [CW-1:0]        out_count;
  logic                 out_last;

  logic                 busy;
  logic [15:0]          ones_count;

  modport master (
    output thr_wr_en, thr_wr_addr, thr_wr_data, thr_wr_inv,
    output in_valid, in_sum, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_count, out_last, busy, ones_count
  );

  modport slave (
    input  thr_wr_en, thr_wr_addr, thr_wr_data, thr_wr_inv,
    input  in_valid, in_sum, in_last, out_ready,
    output in_ready, out_valid, out_word, out_count, out_last, busy, ones_count
  );

endinterface

// File: rtl/bnn_threshold_table.sv
// Per-neuron threshold/polarity register file: one write port, one
// combinational read port, so a same-cycle write is seen only next cycle.
module bnn_threshold_table
  import bnn_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  localparam int AW = $clog2(NUM_NEURONS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [AW-1:0] wr_addr,
  input  thr_entry_t wr_entry,
  input  logic [AW-1:0] rd_addr,
  output thr_entry_t rd_entry
);

  thr_entry_t entries [NUM_NEURONS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = entries[rd_addr];

endmodule

// File: rtl/bnn_threshold_packer.sv
// Thresholds accumulated neuron sums into activation bits and packs them
// LSB-first into words. Macro BNN_PACK_STATS_EN builds the ones counter.
//
// state   | meaning
// S_EMPTY | no bits pending in the pack register (bit_pos = 0)
// S_FILL  | partial word pending in the pack register
module bnn_threshold_packer
  import bnn_pkg::*;
#(
  parameter int WORD_SIZE   = BNN_WORD_SIZE,
  parameter int ACC_W       = BNN_ACC_W,
  parameter int NUM_NEURONS = 256
) (
  input logic             clk,
  input logic             reset,
  bnn_threshold_packer_if.slave bus
);

  localparam int AW = $clog2(NUM_NEURONS);
  localparam int BW = $clog2(WORD_SIZE);
  localparam int CW = $clog2(WORD_SIZE + 1);
  localparam logic [BW-1:0] LAST_POS = BW'(WORD_SIZE - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);

  pack_state_t          state, state_next;
  logic [AW-1:0]        idx;
  logic [BW-1:0]        bit_pos;
  logic [WORD_SIZE-1:0] pack, pack_next;
  thr_entry_t           entry, wr_entry;
  logic                 accept, act_bit, complete;

  assign wr_entry = '{inv: bus.thr_wr_inv, thr: bus.thr_wr_data};

  bnn_threshold_table #(.NUM_NEURONS(NUM_NEURONS)) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.thr_wr_en),
    .wr_addr  (bus.thr_wr_addr),
    .wr_entry (wr_entry),
    .rd_addr  (idx),
    .rd_entry (entry)
  );

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign act_bit      = entry.inv ? (bus.in_sum < entry.thr) : (bus.in_sum >= entry.thr);
  assign complete     = accept && ((bit_pos == LAST_POS) || bus.in_last);
  assign pack_next    = pack | (WORD_SIZE'(act_bit) << bit_pos);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (accept && !complete) state_next = S_FILL;
      S_FILL:  if (complete)            state_next = S_EMPTY;
      default:                          state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      bit_pos <= '0;
      pack    <= '0;
    end else if (accept) begin
      idx <= (bus.in_last || idx == LAST_IDX) ? '0 : idx + AW'(1);
      if (complete) begin
        bit_pos <= '0;
        pack    <= '0;
      end else begin
        bit_pos <= bit_pos + BW'(1);
        pack    <= pack_next;
      end
    end
  end

  // The completing bit goes straight into the output word, so no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_word  <= '0;
      bus.out_count <= '0;
      bus.out_last  <= 1'b0;
    end else if (complete) begin
      bus.out_valid <= 1'b1;
      bus.out_word  <= pack_next;
      bus.out_count <= CW'(bit_pos) + CW'(1);
      bus.out_last  <= bus.in_last;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  assign bus.busy = (state == S_FILL) || bus.out_valid;

`ifdef BNN_PACK_STATS_EN
  logic [15:0] word_ones;

  always_comb begin
    word_ones = '0;
    for (int i = 0; i < WORD_SIZE; i++) word_ones = word_ones + 16'(bus.out_word[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            bus.ones_count <= '0;
    else if (bus.out_valid && bus.out_ready) bus.ones_count <= sat_add16(bus.ones_count, word_ones);
  end
`else
  assign bus.ones_count = '0;
`endif

endmodule

// File: tb/tb_bnn_threshold_packer.sv
// Scoreboard bench for bnn_threshold_packer: a bit-queue reference model
// predicts packed words; a negedge monitor compares every output cycle.
module tb_bnn_threshold_packer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bnn_threshold_packer_if #(.WORD_SIZE(64), .ACC_W(16), .NUM_NEURONS(256)) bus ();

  bnn_threshold_packer #(.WORD_SIZE(64), .ACC_W(16), .NUM_NEURONS(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] word;
    int          count;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  bit          bits[$];
  int          idx_m;
  int          thr_m[256];
  bit          inv_m[256];
  int          ones_m;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          rand_ready = 0;
  logic [63:0] got_word;
  int          got_count;
  bit          got_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, expected handshake at %0t", name, $time);
  endtask

  // Reference model and monitor, evaluated on the falling edge where all
  // inputs for the coming rising edge are already settled.
  always @(negedge clk) begin
    bit          ev, b;
    int          a;
    logic [63:0] w;
    if (reset) begin
      sb.delete();
      bits.delete();
      idx_m  = 0;
      ones_m = 0;
      for (int i = 0; i < 256; i++) begin
        thr_m[i] = 0;
        inv_m[i] = 0;
      end
    end else begin
      ev = (sb.size() != 0);
      chk("out_valid", bus.out_valid, ev);
      chk("in_ready", bus.in_ready, !ev || bus.out_ready);
      chk("busy", bus.busy, ev || (bits.size() != 0));
      chk("ones_count", bus.ones_count, ones_m);
      if (ev && bus.out_valid) begin
        chk("out_word", bus.out_word, sb[0].word);
        chk("out_count", bus.out_count, sb[0].count);
        chk("out_last", bus.out_last, sb[0].last);
        if (bus.out_ready) begin
          got_word  = bus.out_word;
          got_count = int'(bus.out_count);
          got_last  = bus.out_last;
`ifdef BNN_PACK_STATS_EN
          ones_m = ones_m + $countones(sb[0].word);
          if (ones_m > 65535) ones_m = 65535;
`endif
          void'(sb.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        a = int'(bus.in_sum);
        b = inv_m[idx_m] ? (a < thr_m[idx_m]) : (a >= thr_m[idx_m]);
        bits.push_back(b);
        if (bits.size() == 64 || bus.in_last) begin
          w = '0;
          foreach (bits[i]) w[i] = bits[i];
          sb.push_back('{word: w, count: bits.size(), last: bus.in_last});
          bits.delete();
        end
        idx_m = bus.in_last ? 0 : (idx_m + 1) % 256;
      end
      if (bus.thr_wr_en) begin
        thr_m[bus.thr_wr_addr] = int'(bus.thr_wr_data);
        inv_m[bus.thr_wr_addr] = bus.thr_wr_inv;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic write_thr(input int addr, input int data, input bit inv);
    bus.thr_wr_en   = 1'b1;
    bus.thr_wr_addr = 8'(addr);
    bus.thr_wr_data = 16'(data);
    bus.thr_wr_inv  = inv;
    @(posedge clk);
    #1;
    bus.thr_wr_en = 1'b0;
  endtask

  task automatic send_beat(input int sum, input bit last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sum   = 16'(sum);
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        timeout_fail("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !bus.out_valid) break;
      n++;
      if (n > 500) begin
        timeout_fail("drain_timeout");
        break;
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_word", bus.out_word, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_ones_count", bus.ones_count, 0);
  endtask

  initial begin
    bus.thr_wr_en   = 1'b0;
    bus.thr_wr_addr = '0;
    bus.thr_wr_data = '0;
    bus.thr_wr_inv  = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_sum      = '0;
    bus.in_last     = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Alternating sums around a uniform threshold of 32.
    for (int i = 0; i < 256; i++) write_thr(i, 32, 0);
    for (int i = 0; i < 64; i++) send_beat((i % 2 == 0) ? 40 : 10, 0);
    wait_drain();
    chk("t1_word", got_word, 64'h5555_5555_5555_5555);
    chk("t1_count", got_count, 64);
    chk("t1_last", got_last, 0);

    // Short layer with a mixed-polarity entry.
    send_beat(0, 1);
    wait_drain();
    write_thr(0, 5, 0);
    write_thr(1, 5, 1);
    write_thr(2, 5, 0);
    send_beat(5, 0);
    send_beat(4, 0);
    send_beat(6, 1);
    wait_drain();
    chk("t2_word", got_word, 64'h7);
    chk("t2_count", got_count, 3);
    chk("t2_last", got_last, 1);
    send_beat(5, 1);
    wait_drain();
    chk("t2_idx_reset", got_word, 64'h1);

    // Consumer stalls ten cycles after the first word completes.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) send_beat($urandom_range(0, 40), 0);
    fork
      send_beat($urandom_range(0, 40), 0);
      begin
        repeat (10) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 63; i++) send_beat($urandom_range(0, 40), 0);
    wait_drain();
    chk("t3_count", got_count, 64);

    // Same-cycle write and read of entry 0 sees the old threshold.
    send_beat(0, 1);
    wait_drain();
    write_thr(0, 0, 0);
    bus.thr_wr_en   = 1'b1;
    bus.thr_wr_addr = 8'd0;
    bus.thr_wr_data = 16'd100;
    bus.thr_wr_inv  = 1'b0;
    send_beat(50, 1);
    bus.thr_wr_en = 1'b0;
    wait_drain();
    chk("rbw_old", got_word, 64'h1);
    send_beat(50, 1);
    wait_drain();
    chk("rbw_new", got_word, 64'h0);

    // Reset in the middle of a word.
    for (int i = 0; i < 20; i++) send_beat($urandom_range(0, 200), 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) send_beat($urandom_range(0, 200), 0);
    wait_drain();
    chk("post_rst_word", got_word, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_rst_count", got_count, 64);

    // Second all-ones word for the ones statistic.
    for (int i = 0; i < 64; i++) send_beat($urandom_range(0, 200), 0);
    wait_drain();
`ifdef BNN_PACK_STATS_EN
    chk("ones_total", bus.ones_count, 128);
`else
    chk("ones_total", bus.ones_count, 0);
`endif

    // Randomized traffic: thresholds, polarity, layer ends, backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.thr_wr_en   = 1'b1;
        bus.thr_wr_addr = 8'($urandom_range(0, 255));
        bus.thr_wr_data = 16'($urandom_range(0, 80));
        bus.thr_wr_inv  = 1'($urandom_range(0, 1));
      end
      send_beat($urandom_range(0, 80), $urandom_range(0, 39) == 0);
      bus.thr_wr_en = 1'b0;
    end
    rand_ready = 1'b0;
    wait_drain();
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
